// File: rtl/cbus_router_pkg.sv
// Shared CBus types plus the router's state encoding and default MMIO decode constants.
package cbus_router_pkg;

   typedef enum logic [7:0] {
      MLEN1  = 8'd0,
      MLEN2  = 8'd1,
      MLEN4  = 8'd3,
      MLEN8  = 8'd7,
      MLEN16 = 8'd15
   } mlen_t;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      mlen_t       len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAM  = 2'd1,
      MMIO = 2'd2,
      ERR  = 2'd3
   } router_state_t;

   localparam logic [63:0] CBUS_ROUTER_MMIO_BASE_DEFAULT = 64'h0000_0000;
   localparam logic [63:0] CBUS_ROUTER_MMIO_MASK_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/cbus_addr_decode.sv
// Combinational CBus target decode: MMIO hit on masked compare; MMIO bursts are illegal.
module cbus_addr_decode
   import cbus_router_pkg::*;
#(
   parameter logic [63:0] MMIO_BASE = CBUS_ROUTER_MMIO_BASE_DEFAULT,
   parameter logic [63:0] MMIO_MASK = CBUS_ROUTER_MMIO_MASK_DEFAULT
) (
   input  logic [63:0] i_addr,
   input  mlen_t       i_len,
   output logic        o_is_mmio,
   output logic        o_illegal
);

   logic w_hit;

   assign w_hit     = (i_addr & MMIO_MASK) == MMIO_BASE;
   assign o_is_mmio = w_hit;
   assign o_illegal = w_hit && (i_len != MLEN1);

endmodule

// File: rtl/cbus_router.sv
// Routes one CBus stream to RAM or MMIO, holding the target for a whole burst.
// Optional downstream timeout enabled by defining CBUS_ROUTER_TIMEOUT_EN.
module cbus_router
   import cbus_router_pkg::*;
#(
   parameter logic [63:0] MMIO_BASE      = CBUS_ROUTER_MMIO_BASE_DEFAULT,
   parameter logic [63:0] MMIO_MASK      = CBUS_ROUTER_MMIO_MASK_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  ireq,
   output cbus_resp_t iresp,
   output cbus_req_t  ram_req,
   input  cbus_resp_t ram_resp,
   output cbus_req_t  mmio_req,
   input  cbus_resp_t mmio_resp,
   output logic       busy,
   output logic       err
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("cbus_router: TIMEOUT_CYCLES must fit the 16-bit wait counter");
   end

   router_state_t r_state;
   logic [7:0]    r_beat;
   logic          r_busy;
   logic          r_err;

   logic       w_is_mmio;
   logic       w_illegal;
   logic       w_timeout;
   logic       w_err_last;
   cbus_resp_t w_sel_resp;

   cbus_addr_decode #(
      .MMIO_BASE(MMIO_BASE),
      .MMIO_MASK(MMIO_MASK)
   ) u_decode (
      .i_addr   (ireq.addr),
      .i_len    (ireq.len),
      .o_is_mmio(w_is_mmio),
      .o_illegal(w_illegal)
   );

   assign w_sel_resp = (r_state == MMIO) ? mmio_resp : ram_resp;
   assign w_err_last = (r_beat == 8'(ireq.len));

`ifdef CBUS_ROUTER_TIMEOUT_EN
   logic [15:0] r_wait;

   // Counts consecutive forwarding cycles without a downstream ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wait <= '0;
      end else if (((r_state != RAM) && (r_state != MMIO)) || w_sel_resp.ready) begin
         r_wait <= '0;
      end else if (!w_timeout) begin
         r_wait <= r_wait + 16'd1;
      end
   end

   assign w_timeout = ((r_state == RAM) || (r_state == MMIO)) &&
                      (r_wait == 16'(TIMEOUT_CYCLES));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ireq.valid) begin
                  r_beat <= '0;
                  r_busy <= 1'b1;
                  if (w_illegal) begin
                     r_state <= ERR;
                     r_err   <= 1'b1;
                  end else if (w_is_mmio) begin
                     r_state <= MMIO;
                  end else begin
                     r_state <= RAM;
                  end
               end
            end
            RAM, MMIO: begin
               if (!ireq.valid) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_timeout) begin
                  // beat count is kept so ERR pads out exactly the missing beats
                  r_state <= ERR;
                  r_err   <= 1'b1;
               end else if (w_sel_resp.ready) begin
                  r_beat <= r_beat + 8'd1;
                  if (w_sel_resp.last) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            ERR: begin
               r_beat <= r_beat + 8'd1;
               if (!ireq.valid || w_err_last) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      iresp    = '0;
      ram_req  = '0;
      mmio_req = '0;
      case (r_state)
         RAM: begin
            if (!w_timeout) ram_req = ireq;
            iresp = ram_resp;
         end
         MMIO: begin
            if (!w_timeout) mmio_req = ireq;
            iresp = mmio_resp;
         end
         ERR: begin
            iresp.ready = 1'b1;
            iresp.last  = w_err_last;
            iresp.data  = '0;
         end
         default: begin
            iresp = '0;
         end
      endcase
   end

   assign busy = r_busy;
   assign err  = r_err;

endmodule

// File: tb/tb_cbus_router.sv
// Scoreboard bench for cbus_router: directed transactions push expected upstream beats,
// a negedge monitor pops and compares whenever iresp.ready is seen.
module tb_cbus_router;
   import cbus_router_pkg::*;

   typedef struct {
      logic        last;
      logic [63:0] data;
   } exp_beat_t;

   logic       clk;
   logic       reset;
   cbus_req_t  ireq;
   cbus_resp_t iresp;
   cbus_req_t  ram_req;
   cbus_resp_t ram_resp;
   cbus_req_t  mmio_req;
   cbus_resp_t mmio_resp;
   logic       busy;
   logic       err;

   int nTests = 0;
   int nFail  = 0;
   exp_beat_t expQ[$];

   cbus_router #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ireq     (ireq),
      .iresp    (iresp),
      .ram_req  (ram_req),
      .ram_resp (ram_resp),
      .mmio_req (mmio_req),
      .mmio_resp(mmio_resp),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic cbus_req_t mkReq(input logic wr, input logic [63:0] addr,
                                       input logic [63:0] data, input logic [7:0] strb, input mlen_t len);
      cbus_req_t r;
      r.valid = 1'b1;
      r.write = wr;
      r.addr  = addr;
      r.data  = data;
      r.strb  = strb;
      r.len   = len;
      return r;
   endfunction

   task automatic pushExp(input logic last, input logic [63:0] data);
      exp_beat_t e;
      e.last = last;
      e.data = data;
      expQ.push_back(e);
   endtask

   // Monitor: every upstream beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (reset && iresp.ready) begin
         if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL unexpected beat: got data %h last %0b, expected none", iresp.data, iresp.last);
         end else begin
            exp_beat_t e;
            e = expQ.pop_front();
            checkOutput("resp data", iresp.data, e.data);
            checkOutput("resp last", 64'(iresp.last), 64'(e.last));
         end
      end
   end

   // RAM read: decode bubble, then len+1 beats each preceded by 'latency' idle cycles.
   task automatic applyStimulus(input logic [63:0] addr, input mlen_t len, input int latency,
                                input logic [63:0] data0);
      int beats;
      beats = int'(len) + 1;
      ireq = mkReq(1'b0, addr, '0, '0, len);
      checkOutput("ram valid in decode", 64'(ram_req.valid), 64'd0);
      tick();
      checkOutput("ram valid after decode", 64'(ram_req.valid), 64'd1);
      checkOutput("ram addr", ram_req.addr, addr);
      checkOutput("mmio valid on ram txn", 64'(mmio_req.valid), 64'd0);
      for (int b = 0; b < beats; b++) begin
         repeat (latency) tick();
         checkOutput("busy mid txn", 64'(busy), 64'd1);
         ram_resp.ready = 1'b1;
         ram_resp.last  = (b == beats - 1);
         ram_resp.data  = data0 + 64'(b);
         pushExp(b == beats - 1, data0 + 64'(b));
         tick();
         ram_resp = '0;
      end
      ireq = '0;
      checkOutput("busy after last", 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int vcnt;
      reset     = 1'b0;
      ireq      = '0;
      ram_resp  = '0;
      mmio_resp = '0;
      #12;
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset err", 64'(err), 64'd0);
      checkOutput("reset iresp", 64'(iresp.ready), 64'd0);
      reset = 1'b1;
      tick();

      $display("[TB] RAM single read");
      applyStimulus(64'h8000_1000, MLEN1, 3, 64'h1122334455667788);
      tick();

      $display("[TB] RAM burst of 16");
      applyStimulus(64'h8000_0000, MLEN16, 0, 64'hA000_0000_0000_0000);
      tick();

      $display("[TB] MMIO single write");
      ireq = mkReq(1'b1, 64'h0200_4000, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, MLEN1);
      tick();
      checkOutput("mmio valid", 64'(mmio_req.valid), 64'd1);
      checkOutput("mmio addr", mmio_req.addr, 64'h0200_4000);
      checkOutput("mmio data", mmio_req.data, 64'hDEAD_BEEF_0BAD_F00D);
      checkOutput("mmio strb", 64'(mmio_req.strb), 64'hFF);
      checkOutput("mmio write", 64'(mmio_req.write), 64'd1);
      checkOutput("ram valid on mmio txn", 64'(ram_req.valid), 64'd0);
      mmio_resp.ready = 1'b1;
      mmio_resp.last  = 1'b1;
      mmio_resp.data  = 64'h0;
      pushExp(1'b1, 64'h0);
      tick();
      mmio_resp = '0;
      ireq      = '0;
      checkOutput("err after mmio write", 64'(err), 64'd0);
      tick();

      $display("[TB] Illegal MMIO burst");
      ireq = mkReq(1'b0, 64'h0200_0000, '0, '0, MLEN4);
      for (int b = 0; b < 4; b++) pushExp(b == 3, 64'h0);
      tick();
      for (int b = 0; b < 4; b++) begin
         checkOutput("err sticky", 64'(err), 64'd1);
         checkOutput("no downstream valid", 64'(ram_req.valid | mmio_req.valid), 64'd0);
         tick();
      end
      ireq = '0;
      checkOutput("idle after err burst", 64'(busy), 64'd0);
      tick();

      $display("[TB] Reset mid-burst");
      ireq = mkReq(1'b0, 64'h8000_2000, '0, '0, MLEN8);
      tick();
      for (int b = 0; b < 4; b++) begin
         ram_resp.ready = 1'b1;
         ram_resp.last  = 1'b0;
         ram_resp.data  = 64'h5000 + 64'(b);
         pushExp(1'b0, 64'h5000 + 64'(b));
         tick();
      end
      ram_resp.data = 64'h5004;
      checkOutput("err before reset", 64'(err), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async reset ram_req", 64'(ram_req.valid), 64'd0);
      checkOutput("async reset iresp", 64'(iresp.ready), 64'd0);
      checkOutput("async reset busy", 64'(busy), 64'd0);
      checkOutput("async reset err", 64'(err), 64'd0);
      ireq     = '0;
      ram_resp = '0;
      tick();
      reset = 1'b1;
      tick();
      applyStimulus(64'h8000_3000, MLEN1, 1, 64'h0123_4567_89AB_CDEF);
      checkOutput("err after clean read", 64'(err), 64'd0);
      tick();

`ifdef CBUS_ROUTER_TIMEOUT_EN
      $display("[TB] Downstream timeout");
      ireq = mkReq(1'b0, 64'h8000_4000, '0, '0, MLEN1);
      pushExp(1'b1, 64'h0);
      tick();
      vcnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (iresp.ready) break;
         if (ram_req.valid) vcnt++;
         tick();
      end
      checkOutput("timeout valid cycles", 64'(vcnt), 64'd8);
      checkOutput("timeout err", 64'(err), 64'd1);
      tick();
      ireq = '0;
      checkOutput("idle after timeout", 64'(busy), 64'd0);
      tick();
`else
      vcnt = 0;
`endif

      repeat (2) tick();
      checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
